// File: rtl/buscaminas_input_ctrl.sv
// buscaminas_input_ctrl: five push-buttons -> 8x8 cursor and click coordinates for the game FSM
//  Ports: clk, reset (async, active-low); btn_up/down/left/right/sel raw buttons;
//   board_in revealed mask (bit y*8+x); game_over blocks clicks;
//   cursor_x/cursor_y cursor; click_x/click_y {0,coord} during click else 4'hF;
//   busy high in CLICK; click_rej 1-cycle reject pulse.
//  Optional macro BUSCAMINAS_DEBOUNCE_EN adds a DEB_CYCLES stable-count debounce per button.
module buscaminas_input_ctrl #(
  parameter int CLICK_HOLD = 2,
  parameter int WRAP       = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic [63:0] board_in,
  input  logic        game_over,
  output logic [2:0]  cursor_x,
  output logic [2:0]  cursor_y,
  output logic [3:0]  click_x,
  output logic [3:0]  click_y,
  output logic        busy,
  output logic        click_rej
);
  localparam int HW = $clog2(CLICK_HOLD + 1);
  typedef enum logic {IDLE, CLICK} state_t;
  state_t state, state_n;
  logic [4:0] s1, s2, lvl, prev, edg;
  logic [2:0] cx_n, cy_n;
  logic [3:0] clx_n, cly_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic rej_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= {btn_sel, btn_up, btn_down, btn_left, btn_right};
      s2 <= s1;
      prev <= lvl;
    end
`ifdef BUSCAMINAS_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [4:0] deb;
  logic [CW-1:0] cnt [5];
  // Any sample equal to the debounced level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else
      for (int i = 0; i < 5; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
  assign lvl = deb;
`else
  assign lvl = s2;
`endif
  // edg bits: 4 sel, 3 up, 2 down, 1 left, 0 right; the else-if chain below gives the priority.
  assign edg = lvl & ~prev;
  function automatic logic [2:0] step(input logic [2:0] v, input logic inc);
    return inc ? ((v == 3'd7 && WRAP == 0) ? v : v + 3'd1)
               : ((v == 3'd0 && WRAP == 0) ? v : v - 3'd1);
  endfunction
  always_comb begin
    state_n = state;
    cx_n = cursor_x;
    cy_n = cursor_y;
    clx_n = click_x;
    cly_n = click_y;
    hcnt_n = hcnt;
    rej_n = 1'b0;
    if (state == IDLE) begin
      if (edg[4]) begin
        if (game_over || board_in[{cursor_y, cursor_x}]) rej_n = 1'b1;
        else begin
          state_n = CLICK;
          clx_n = {1'b0, cursor_x};
          cly_n = {1'b0, cursor_y};
          hcnt_n = '0;
        end
      end else if (edg[3]) cy_n = step(cursor_y, 1'b0);
      else if (edg[2]) cy_n = step(cursor_y, 1'b1);
      else if (edg[1]) cx_n = step(cursor_x, 1'b0);
      else if (edg[0]) cx_n = step(cursor_x, 1'b1);
    end else if (game_over || hcnt == HW'(CLICK_HOLD - 1)) begin
      state_n = IDLE;
      clx_n = 4'hF;
      cly_n = 4'hF;
    end else hcnt_n = hcnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cursor_x <= '0;
      cursor_y <= '0;
      click_x <= 4'hF;
      click_y <= 4'hF;
      hcnt <= '0;
      click_rej <= 1'b0;
    end else begin
      state <= state_n;
      cursor_x <= cx_n;
      cursor_y <= cy_n;
      click_x <= clx_n;
      click_y <= cly_n;
      hcnt <= hcnt_n;
      click_rej <= rej_n;
    end
  assign busy = (state == CLICK);
endmodule

// File: tb/tb_buscaminas_input_ctrl.sv
// tb_buscaminas_input_ctrl: directed self-checking bench for buscaminas_input_ctrl
module tb_buscaminas_input_ctrl;
`ifdef BUSCAMINAS_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, reset = 1'b0, game_over = 1'b0;
  logic [4:0] btn = '0;
  logic [63:0] board_in = '0;
  logic [2:0] cursor_x, cursor_y, cx0, cy0;
  logic [3:0] click_x, click_y, kx0, ky0;
  logic busy, click_rej, b0, r0;
  int nv = 0, nerr = 0;
  always #5 clk = ~clk;
  buscaminas_input_ctrl dut (.clk(clk), .reset(reset), .btn_up(btn[3]), .btn_down(btn[2]),
    .btn_left(btn[1]), .btn_right(btn[0]), .btn_sel(btn[4]), .board_in(board_in),
    .game_over(game_over), .cursor_x(cursor_x), .cursor_y(cursor_y), .click_x(click_x),
    .click_y(click_y), .busy(busy), .click_rej(click_rej));
  buscaminas_input_ctrl #(.WRAP(0)) dut0 (.clk(clk), .reset(reset), .btn_up(btn[3]),
    .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]), .btn_sel(btn[4]),
    .board_in(board_in), .game_over(game_over), .cursor_x(cx0), .cursor_y(cy0),
    .click_x(kx0), .click_y(ky0), .busy(b0), .click_rej(r0));
  // btn bits: 4 sel, 3 up, 2 down, 1 left, 0 right
  task automatic press(input logic [4:0] b);
    btn = b;
    repeat (LAT + 2) @(negedge clk);
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    nv++;
    if ({cursor_x, cursor_y, click_x, click_y, busy, click_rej} !== {3'd0, 3'd0, 4'hF, 4'hF, 2'b00}) begin
      nerr++;
      $display("FAIL reset_state got %h %h %h %h %b %b", cursor_x, cursor_y, click_x, click_y, busy, click_rej);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_wrap;
    press(5'b00010);
    nv++;
    if (cursor_x !== 3'd7) begin nerr++; $display("FAIL wrap_left got %0d exp 7", cursor_x); end
    nv++;
    if (cx0 !== 3'd0) begin nerr++; $display("FAIL sat_left got %0d exp 0", cx0); end
    press(5'b01000);
    nv++;
    if (cursor_y !== 3'd7) begin nerr++; $display("FAIL wrap_up got %0d exp 7", cursor_y); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_click;
    repeat (3) press(5'b00001);
    repeat (2) press(5'b00100);
    nv++;
    if ({cursor_x, cursor_y} !== {3'd3, 3'd2}) begin nerr++; $display("FAIL move got %0d,%0d exp 3,2", cursor_x, cursor_y); end
    btn = 5'b10000;
    repeat (LAT - 1) @(negedge clk);
    nv++;
    if ({click_x, click_y, busy} !== {4'hF, 4'hF, 1'b0}) begin nerr++; $display("FAIL click_early got %h %h %b", click_x, click_y, busy); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nv++;
      if ({click_x, click_y, busy} !== {4'h3, 4'h2, 1'b1}) begin nerr++; $display("FAIL click_hold%0d got %h %h %b exp 3 2 1", i, click_x, click_y, busy); end
    end
    @(negedge clk);
    nv++;
    if ({click_x, click_y, busy} !== {4'hF, 4'hF, 1'b0}) begin nerr++; $display("FAIL click_end got %h %h %b", click_x, click_y, busy); end
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask
  task automatic test_revealed;
    board_in = 64'h1 << 19;
    btn = 5'b10000;
    repeat (LAT) @(negedge clk);
    nv++;
    if ({click_rej, busy, click_x} !== {2'b10, 4'hF}) begin nerr++; $display("FAIL rej_pulse got %b %b %h", click_rej, busy, click_x); end
    @(negedge clk);
    nv++;
    if ({click_rej, busy} !== 2'b00) begin nerr++; $display("FAIL rej_clear got %b %b", click_rej, busy); end
    btn = '0;
    board_in = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask
  task automatic test_priority;
    repeat (2) press(5'b00010);
    press(5'b01000);
    btn = 5'b11000;
    repeat (LAT) @(negedge clk);
    nv++;
    if ({click_x, click_y, cursor_y} !== {4'h1, 4'h1, 3'd1}) begin nerr++; $display("FAIL sel_prio got %h %h y=%0d exp 1 1 1", click_x, click_y, cursor_y); end
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
    btn = 5'b00001;
    repeat (12) @(negedge clk);
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
    nv++;
    if (cursor_x !== 3'd2) begin nerr++; $display("FAIL held_right got %0d exp 2", cursor_x); end
  endtask
  task automatic test_game_over;
    btn = 5'b10000;
    repeat (LAT) @(negedge clk);
    nv++;
    if ({busy, click_x, click_y} !== {1'b1, 4'h2, 4'h1}) begin nerr++; $display("FAIL go_click got %b %h %h", busy, click_x, click_y); end
    game_over = 1'b1;
    @(negedge clk);
    nv++;
    if ({busy, click_x, click_y} !== {1'b0, 4'hF, 4'hF}) begin nerr++; $display("FAIL go_abort got %b %h %h", busy, click_x, click_y); end
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
    btn = 5'b10000;
    repeat (LAT) @(negedge clk);
    nv++;
    if ({click_rej, busy} !== 2'b10) begin nerr++; $display("FAIL go_rej got %b %b", click_rej, busy); end
    btn = '0;
    repeat (LAT + 2) @(negedge clk);
    press(5'b00001);
    nv++;
    if (cursor_x !== 3'd3) begin nerr++; $display("FAIL go_move got %0d exp 3", cursor_x); end
    game_over = 1'b0;
`ifdef BUSCAMINAS_DEBOUNCE_EN
    btn = 5'b10000;
    repeat (2) @(negedge clk);
    btn = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nv++;
      if (busy !== 1'b0) begin nerr++; $display("FAIL glitch_click cycle %0d busy=%b", i, busy); end
    end
`endif
  endtask
  task automatic test_async_reset;
    btn = 5'b10000;
    repeat (LAT) @(negedge clk);
    nv++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL pre_reset_busy got %b", busy); end
    #2 reset = 1'b0;
    #1;
    nv++;
    if ({cursor_x, cursor_y, click_x, click_y, busy, click_rej} !== {3'd0, 3'd0, 4'hF, 4'hF, 2'b00}) begin
      nerr++;
      $display("FAIL async_reset got %h %h %h %h %b %b", cursor_x, cursor_y, click_x, click_y, busy, click_rej);
    end
    btn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    test_reset;
    test_wrap;
    test_click;
    test_revealed;
    test_priority;
    test_game_over;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
